// File: rtl/mmio_led_streamer_pkg.sv
// Shared types and constants for the MMIO APA102 LED streamer.
package led_streamer_pkg;

    typedef enum logic [2:0] {IDLE, START, LOAD, PIXEL, END} state_t;

    localparam logic [31:0] DEF_PIX_ADDR  = 32'h0000_0F00;
    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0000_0F01;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0F02;

    localparam int OVF_BIT    = 9;
    localparam int BUSY_BIT   = 8;
    localparam int FRAME_BITS = 32;

endpackage

// File: rtl/mmio_led_streamer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted when a pop lands in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_led_streamer.sv
// Store-bus peripheral: queues APA102 pixel words and serializes one strip refresh per control store.
module mmio_led_streamer
    import led_streamer_pkg::*;
#(
    parameter logic [31:0] PIX_ADDR   = DEF_PIX_ADDR,
    parameter logic [31:0] CTRL_ADDR  = DEF_CTRL_ADDR,
    parameter logic [31:0] STAT_ADDR  = DEF_STAT_ADDR,
    parameter int          FIFO_DEPTH = 16,
    parameter int          NUM_LEDS   = 8,
    parameter int          CLK_DIV    = 4,
    parameter int          END_BITS   = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    output logic [31:0] q_status,
    output logic        q_status_valid,
    output logic        sck,
    output logic        sdo,
    output logic        busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(2*CLK_DIV + 1);
    localparam int BW = (END_BITS > 63) ? $clog2(END_BITS + 1) : 6;
    localparam int LW = $clog2(NUM_LEDS + 1);

    localparam logic [DW-1:0] DIV_HI   = DW'(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(2*CLK_DIV - 1);
    localparam logic [BW-1:0] WORD_END = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] END_DONE = BW'(END_BITS);
    localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);

    state_t            state, state_n;
    logic [DW-1:0]     div, div_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [LW-1:0]     led_cnt, led_n;
    logic [31:0]       shreg, shreg_n;
    logic              overflow, pop, bit_end;
    logic              push_req, ctrl_wr;
    logic [31:0]       fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    assign push_req       = wren && (address_dmem == PIX_ADDR);
    assign ctrl_wr        = wren && (address_dmem == CTRL_ADDR);
    assign q_status_valid = (address_dmem == STAT_ADDR);
    assign busy           = (state != IDLE);
    assign sck            = (div >= DIV_HI);
    assign sdo            = shreg[31];
    assign bit_end        = (div == DIV_LAST);

    always_comb begin
        q_status           = '0;
        q_status[4:0]      = 5'(fifo_count);
        q_status[BUSY_BIT] = busy;
        q_status[OVF_BIT]  = overflow;
    end

    sync_fifo #(.DATA_WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            led_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_cnt <= bit_n;
            led_cnt <= led_n;
            shreg   <= shreg_n;
        end
    end

    // sdo is the shift register MSB: zeros for the start frame, ones for the end frame.
    always_comb begin
        state_n = state;
        div_n   = div;
        bit_n   = bit_cnt;
        led_n   = led_cnt;
        shreg_n = shreg;
        pop     = 1'b0;
        if (state inside {START, PIXEL} || (state == END && bit_cnt != END_DONE))
            div_n = bit_end ? '0 : div + 1'b1;
        case (state)
            IDLE: if (ctrl_wr && data[0]) begin
                state_n = START;
                div_n   = '0;
                bit_n   = '0;
                shreg_n = '0;
            end
            START: if (bit_end) begin
                if (bit_cnt == WORD_END) begin
                    state_n = LOAD;
                    led_n   = '0;
                end else begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
            LOAD: if (!fifo_empty) begin
                pop     = 1'b1;
                shreg_n = fifo_dout;
                bit_n   = '0;
                state_n = PIXEL;
            end
            PIXEL: if (bit_end) begin
                // The last pixel bit is not shifted out so an underflow stall holds sdo.
                if (bit_cnt == WORD_END) begin
                    if (led_cnt == LED_LAST) begin
                        state_n = END;
                        bit_n   = '0;
                        shreg_n = '1;
                    end else begin
                        led_n   = led_cnt + 1'b1;
                        state_n = LOAD;
                    end
                end else begin
                    bit_n   = bit_cnt + 1'b1;
                    shreg_n = {shreg[30:0], 1'b0};
                end
            end
            END: begin
                if (bit_cnt == END_DONE) begin
                    state_n = IDLE;
                    shreg_n = '0;
                end else if (bit_end) begin
                    bit_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A set from a dropped push takes priority over a same-cycle clear.
    always_ff @(posedge clock) begin
        if (!reset)
            overflow <= 1'b0;
        else if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
        else if (ctrl_wr && data[1])
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_mmio_led_streamer.sv
// Self-checking bench: status vectors, reset abort, overflow, full-FIFO frames, random pushes and underflow stall.
module tb_mmio_led_streamer;
    localparam int NL = 2;
    localparam int CD = 2;
    localparam int EB = 32;
    localparam int FD = 16;
    localparam logic [31:0] PIX  = 32'h0000_0F00;
    localparam logic [31:0] CTRL = 32'h0000_0F01;
    localparam logic [31:0] STAT = 32'h0000_0F02;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wren = 1'b0;
    logic [31:0] address_dmem = STAT;
    logic [31:0] data = '0;
    logic [31:0] q_status;
    logic        q_status_valid, sck, sdo, busy;

    mmio_led_streamer #(
        .FIFO_DEPTH(FD), .NUM_LEDS(NL), .CLK_DIV(CD), .END_BITS(EB)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wren           (wren),
        .address_dmem   (address_dmem),
        .data           (data),
        .q_status       (q_status),
        .q_status_valid (q_status_valid),
        .sck            (sck),
        .sdo            (sdo),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Strip-side view: every bit the LEDs would latch.
    bit mon_q[$];
    always @(posedge sck) mon_q.push_back(sdo);

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending pixel words plus the sticky flag.
    logic [31:0] fq[$];
    bit          ovf_m = 1'b0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] dat;
        bit          exp_valid;
        logic [31:0] exp_stat;
    } vec_t;
    vec_t vt[8];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit b);
        return {22'b0, ovf_m, b, 3'b0, 5'(fq.size())};
    endfunction

    task automatic store(input logic [31:0] addr, input logic [31:0] d);
        wren = 1'b1;
        address_dmem = addr;
        data = d;
        tick;
        wren = 1'b0;
        address_dmem = STAT;
    endtask

    task automatic push_m(input logic [31:0] w);
        store(PIX, w);
        if (fq.size() < FD) fq.push_back(w);
        else ovf_m = 1'b1;
    endtask

    // One refresh: optional push at cycle push_at, optional extra start at ctrl_at,
    // optional underflow-stall checks, optional random pushes.
    task automatic run_frame(input int push_at, input int ctrl_at, input bit stall, input bit rnd);
        int cyc, base, ngrp;
        bit sck_seen;
        logic [31:0] w, act, exp;
        bit eb[$];
        base = mon_q.size();
        store(CTRL, 32'h1);
        check("busy_after_start", busy, 1);
        cyc = 0;
        sck_seen = 1'b0;
        while (busy && cyc < 4000) begin
            wren = 1'b0;
            address_dmem = STAT;
            if (cyc + 1 == push_at) begin
                w = $urandom;
                wren = 1'b1; address_dmem = PIX; data = w;
                fq.push_back(w);
            end else if (cyc + 1 == ctrl_at) begin
                wren = 1'b1; address_dmem = CTRL; data = 32'h1;
            end else if (rnd && fq.size() < FD - 1 && $urandom_range(63) == 0) begin
                w = $urandom;
                wren = 1'b1; address_dmem = PIX; data = w;
                fq.push_back(w);
            end
            tick;
            cyc++;
            if (push_at == 129 && cyc == 129) begin
                check("pushpop_count", q_status[4:0], FD);
                check("pushpop_no_ovf", q_status[9], 0);
            end
            if (stall && cyc > 300 && cyc < 400 && sck) sck_seen = 1'b1;
            if (stall && cyc == 400) begin
                check("stall_rises", mon_q.size() - base, 64);
                check("stall_sck_low", sck_seen, 0);
                check("stall_sdo_held", sdo, fq[0][0]);
                check("stall_busy", busy, 1);
            end
        end
        wren = 1'b0;
        address_dmem = STAT;
        check("frame_done", busy, 0);
        if (!stall) check("frame_len", cyc, (32 + 32*NL + EB)*2*CD + NL + 1);
        for (int i = 0; i < 32; i++) eb.push_back(1'b0);
        for (int k = 0; k < NL; k++) begin
            w = fq.pop_front();
            for (int i = 31; i >= 0; i--) eb.push_back(w[i]);
        end
        for (int i = 0; i < EB; i++) eb.push_back(1'b1);
        check("rise_count", mon_q.size() - base, eb.size());
        ngrp = eb.size() / 32;
        for (int g = 0; g < ngrp; g++) begin
            act = 'x;
            exp = '0;
            for (int i = 0; i < 32; i++) begin
                exp = {exp[30:0], eb[g*32 + i]};
                if (base + g*32 + i < mon_q.size())
                    act = {act[30:0], mon_q[base + g*32 + i]};
            end
            check($sformatf("frame_word%0d", g), act, exp);
        end
        check("status_after", q_status, exp_status(1'b0));
    endtask

    initial begin
        int base, nfr;

        vt[0] = '{1'b1, PIX,          32'hA1A1_0001, 1'b0, 32'h1};
        vt[1] = '{1'b0, STAT,         32'h0,         1'b1, 32'h1};
        vt[2] = '{1'b1, PIX,          32'hB2B2_0002, 1'b0, 32'h2};
        vt[3] = '{1'b1, 32'h0000_0F03, 32'hDEAD_BEEF, 1'b0, 32'h2};
        vt[4] = '{1'b1, CTRL,         32'h2,         1'b0, 32'h2};
        vt[5] = '{1'b1, STAT,         32'hFFFF,      1'b1, 32'h2};
        vt[6] = '{1'b0, PIX,          32'h1234_5678, 1'b0, 32'h2};
        vt[7] = '{1'b1, PIX,          32'hC3C3_0003, 1'b0, 32'h3};

        repeat (3) tick;
        check("rst_status", q_status, 32'h0);
        check("rst_busy", busy, 0);
        check("rst_sck", sck, 0);
        check("rst_sdo", sdo, 0);
        reset = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            wren = vt[i].wr; address_dmem = vt[i].addr; data = vt[i].dat;
            #1;
            check($sformatf("vec%0d_valid", i), q_status_valid, vt[i].exp_valid);
            tick;
            check($sformatf("vec%0d_status", i), q_status, vt[i].exp_stat);
            if (vt[i].wr && vt[i].addr == PIX) fq.push_back(vt[i].dat);
        end
        wren = 1'b0;
        address_dmem = STAT;

        // Abort a frame during bit 10 of the start frame.
        store(CTRL, 32'h1);
        check("abort_busy_start", busy, 1);
        repeat (41) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_sck", sck, 0);
        check("abort_sdo", sdo, 0);
        check("abort_status", q_status, 32'h0);
        fq.delete();
        ovf_m = 1'b0;
        base = mon_q.size();
        repeat (50) tick;
        check("abort_no_bits", mon_q.size() - base, 0);

        for (int i = 0; i < 17; i++) push_m($urandom);
        check("ovf_status", q_status, 32'h0000_0210);
        check("ovf_model", q_status, exp_status(1'b0));
        check("ovf_valid", q_status_valid, 1);
        store(CTRL, 32'h2);
        ovf_m = 1'b0;
        check("ovf_clear", q_status, 32'h0000_0010);

        // Full FIFO: push on the first pop cycle, plus a start request mid-frame.
        run_frame(129, 300, 1'b0, 1'b0);

        nfr = 0;
        while (fq.size() >= NL && nfr < 20) begin
            run_frame(0, 0, 1'b0, nfr < 3);
            nfr++;
        end

        if (fq.size() == 0) push_m($urandom);
        run_frame(400, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
